// File: rtl/grf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline W stage (fixed priority) versus a
// small FIFO of long-latency B results, with an anti-starvation W-stage hold.
module grf_wport_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_we,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic [31:0] a_pc,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    input  logic [31:0] b_pc,
    input  logic [4:0]  rd_reg1,
    input  logic [4:0]  rd_reg2,
    output logic        pend_hit1,
    output logic        pend_hit2,
    output logic        RegWrite,
    output logic [4:0]  write_reg,
    output logic [31:0] wdata,
    output logic [31:0] PC,
    output logic        a_hold,
    output logic [2:0]  fifo_cnt,
    output logic        proto_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    logic [4:0]       r_mem_reg  [DEPTH];
    logic [31:0]      r_mem_data [DEPTH];
    logic [31:0]      r_mem_pc   [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic [STV_W-1:0] r_starve;
    logic             r_hold;
    logic             r_proto;

    logic             w_a_req;
    logic             w_nonempty;
    logic             w_full;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_enq;
    logic [DEPTH-1:0] w_valid;

    assign w_a_req    = a_we && (a_reg != 5'd0);
    assign w_nonempty = (r_cnt != '0);
    assign w_full     = (r_cnt == CNT_W'(DEPTH));

    // A hold cycle forces the FIFO head through; otherwise A wins over B.
    assign w_grant_b = !reset && w_nonempty && (r_hold || !w_a_req);
    assign w_grant_a = !reset && w_a_req && !w_grant_b;
    assign w_enq     = !reset && b_valid && !w_full && (b_reg != 5'd0);

    assign b_ready   = !w_full;
    assign a_hold    = r_hold;
    assign proto_err = r_proto;
    assign fifo_cnt  = 3'(r_cnt);

    always_comb begin
        RegWrite  = 1'b0;
        write_reg = 5'd0;
        wdata     = 32'd0;
        PC        = 32'd0;
        if (w_grant_b) begin
            RegWrite  = 1'b1;
            write_reg = r_mem_reg[r_rptr];
            wdata     = r_mem_data[r_rptr];
            PC        = r_mem_pc[r_rptr];
        end else if (w_grant_a) begin
            RegWrite  = 1'b1;
            write_reg = a_reg;
            wdata     = a_data;
            PC        = a_pc;
        end
    end

    // Occupancy mask: slot i is live when its distance from the head is below the count.
    always_comb begin
        w_valid   = '0;
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - r_rptr)) < r_cnt;
            if (w_valid[i] && (rd_reg1 != 5'd0) && (r_mem_reg[i] == rd_reg1)) pend_hit1 = 1'b1;
            if (w_valid[i] && (rd_reg2 != 5'd0) && (r_mem_reg[i] == rd_reg2)) pend_hit2 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_reg[r_wptr]  <= b_reg;
            r_mem_data[r_wptr] <= b_data;
            r_mem_pc[r_wptr]   <= b_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_starve <= '0;
            r_hold   <= 1'b0;
            r_proto  <= 1'b0;
        end else begin
            if (w_enq)     r_wptr <= r_wptr + PTR_W'(1);
            if (w_grant_b) r_rptr <= r_rptr + PTR_W'(1);
            if (w_enq && !w_grant_b)      r_cnt <= r_cnt + CNT_W'(1);
            else if (!w_enq && w_grant_b) r_cnt <= r_cnt - CNT_W'(1);

            if (r_hold && w_a_req) r_proto <= 1'b1;

            r_hold <= 1'b0;
            if (w_grant_b || !w_nonempty) begin
                r_starve <= '0;
            end else if (w_grant_a) begin
                if (r_starve == STV_W'(STARVE_MAX - 1)) begin
                    r_starve <= '0;
                    r_hold   <= 1'b1;
                end else begin
                    r_starve <= r_starve + STV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Randomized bench for grf_wport_arbiter against a queue-based model of the
// write-port arbitration rules.
module tb_grf_wport_arbiter;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_we;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic [31:0] a_pc;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic [31:0] b_pc;
    logic [4:0]  rd_reg1;
    logic [4:0]  rd_reg2;
    logic        pend_hit1;
    logic        pend_hit2;
    logic        RegWrite;
    logic [4:0]  write_reg;
    logic [31:0] wdata;
    logic [31:0] PC;
    logic        a_hold;
    logic [2:0]  fifo_cnt;
    logic        proto_err;

    grf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) u_dut (
        .clk(clk), .reset(reset),
        .a_we(a_we), .a_reg(a_reg), .a_data(a_data), .a_pc(a_pc),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data), .b_pc(b_pc),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
        .RegWrite(RegWrite), .write_reg(write_reg), .wdata(wdata), .PC(PC),
        .a_hold(a_hold), .fifo_cnt(fifo_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t q[$];
    int   starve;
    bit   hold;
    bit   proto;
    int   errors = 0;
    int   checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [4:0] rd);
        if (rd == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].r == rd) return 1'b1;
        return 1'b0;
    endfunction

    // Called at a negedge with inputs driven; checks outputs, then advances the model one edge.
    task automatic step();
        bit   areq, rdy, ga, gb, nh;
        ent_t e;
        ent_t n;
        #1;
        areq = a_we && (a_reg != 5'd0);
        rdy  = q.size() < DEPTH;
        ga = 1'b0;
        gb = 1'b0;
        e  = '{r: 5'd0, d: 32'd0, p: 32'd0};
        if (!reset) begin
            if (hold && q.size() > 0)  gb = 1'b1;
            else if (areq)             ga = 1'b1;
            else if (q.size() > 0)     gb = 1'b1;
        end
        if (gb) e = q[0];
        if (ga) e = '{r: a_reg, d: a_data, p: a_pc};
        check_eq("RegWrite",  32'(RegWrite),  32'(ga || gb));
        check_eq("write_reg", 32'(write_reg), 32'(e.r));
        check_eq("wdata",     wdata,          e.d);
        check_eq("PC",        PC,             e.p);
        check_eq("b_ready",   32'(b_ready),   32'(rdy));
        check_eq("fifo_cnt",  32'(fifo_cnt),  32'(q.size()));
        check_eq("a_hold",    32'(a_hold),    32'(hold));
        check_eq("proto_err", 32'(proto_err), 32'(proto));
        check_eq("pend_hit1", 32'(pend_hit1), 32'(model_hit(rd_reg1)));
        check_eq("pend_hit2", 32'(pend_hit2), 32'(model_hit(rd_reg2)));
        @(posedge clk);
        if (reset) begin
            q.delete();
            starve = 0;
            hold   = 1'b0;
            proto  = 1'b0;
        end else begin
            if (hold && areq) proto = 1'b1;
            nh = 1'b0;
            if (gb || q.size() == 0) begin
                starve = 0;
            end else if (ga) begin
                starve++;
                if (starve == STARVE_MAX) begin
                    starve = 0;
                    nh     = 1'b1;
                end
            end
            if (gb) void'(q.pop_front());
            if (b_valid && rdy && b_reg != 5'd0) begin
                n = '{r: b_reg, d: b_data, p: b_pc};
                q.push_back(n);
            end
            hold = nh;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset   = 1'b0;
        a_we    = 1'b0;
        a_reg   = 5'd0;
        a_data  = 32'd0;
        a_pc    = 32'd0;
        b_valid = 1'b0;
        b_reg   = 5'd0;
        b_data  = 32'd0;
        b_pc    = 32'd0;
        rd_reg1 = 5'd0;
        rd_reg2 = 5'd0;
    endtask

    task automatic set_a(input logic we, input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
        a_we = we; a_reg = r; a_data = d; a_pc = p;
    endtask

    task automatic set_b(input logic v, input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
        b_valid = v; b_reg = r; b_data = d; b_pc = p;
    endtask

    task automatic drive_rand(input int a_pct, input int b_pct, input int rst_pct);
        reset   = ($urandom_range(0, 99) < rst_pct);
        a_we    = ($urandom_range(0, 99) < a_pct);
        a_reg   = 5'($urandom_range(0, 7));
        a_data  = $urandom;
        a_pc    = $urandom;
        b_valid = ($urandom_range(0, 99) < b_pct);
        b_reg   = 5'($urandom_range(0, 7));
        b_data  = $urandom;
        b_pc    = $urandom;
        rd_reg1 = 5'($urandom_range(0, 7));
        rd_reg2 = 5'($urandom_range(0, 7));
    endtask

    initial begin
        starve = 0;
        hold   = 1'b0;
        proto  = 1'b0;
        idle();
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // Same-cycle A write, then a_reg=0 is not a request
        set_a(1'b1, 5'd5, 32'h1234, 32'h3000);
        step();
        set_a(1'b1, 5'd0, 32'h9999, 32'h3004);
        step();
        set_a(1'b0, 5'd0, 32'd0, 32'd0);

        // B-only traffic, back-to-back pushes with simultaneous enq/deq
        set_b(1'b1, 5'd8, 32'hAA, 32'h4000);
        step();
        set_b(1'b1, 5'd9, 32'hBB, 32'h4004);
        step();
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
        step();
        step();

        // Continuous A while B fills the FIFO: starvation hold and sticky proto_err
        for (int i = 0; i < 10; i++) begin
            set_a(1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h5000 + 32'(4 * i));
            set_b(1'b1, 5'(20 + i), 32'h200 + 32'(i), 32'h6000 + 32'(4 * i));
            step();
        end
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
        set_a(1'b0, 5'd0, 32'd0, 32'd0);
        check_eq("proto_sticky", 32'(proto_err), 32'd1);
        for (int i = 0; i < 4; i++) step();
        check_eq("proto_still", 32'(proto_err), 32'd1);

        // Pending-hazard flag on a buffered reg 12
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_a(1'b1, 5'd3, 32'h33, 32'h7000);
        set_b(1'b1, 5'd12, 32'hC12, 32'h7100);
        rd_reg1 = 5'd12;
        rd_reg2 = 5'd0;
        step();
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
        step();
        check_eq("hit1_buffered", 32'(pend_hit1), 32'd1);
        set_a(1'b0, 5'd0, 32'd0, 32'd0);
        step();
        step();
        check_eq("hit1_cleared", 32'(pend_hit1), 32'd0);

        // b_reg=0 is consumed without enqueue; reset flushes queued entries
        set_b(1'b1, 5'd0, 32'hDEAD, 32'h8000);
        step();
        set_a(1'b1, 5'd4, 32'h44, 32'h8100);
        set_b(1'b1, 5'd14, 32'hE1, 32'h8200);
        step();
        set_b(1'b1, 5'd15, 32'hE2, 32'h8204);
        step();
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_a(1'b0, 5'd0, 32'd0, 32'd0);
        check_eq("flush_cnt", 32'(fifo_cnt), 32'd0);
        step();
        step();

        // Randomized mixed traffic in phases of differing A pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 250; i++) begin
                drive_rand((ph == 1) ? 95 : (ph == 2 ? 20 : 55), (ph == 3) ? 30 : 70, (i == 200) ? 100 : 0);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grf_wport_arbiter.md
Name: grf_wport_arbiter

Overview:
Shares the register file's single write port between two requesters.
- Port A: the pipeline W stage. It has fixed priority and cannot be back-pressured.
- Port B: long-latency result sources (multiply/divide, CP0 reads). These use a valid/ready handshake into a small FIFO.

The block drives the register file's RegWrite/write_reg/wdata/PC inputs. It prevents B starvation by requesting a one-cycle W-stage hold. It also reports read-after-write hazards against buffered B results to the stall logic.

Parameters:
DEPTH, 2, B FIFO entries; power of two, ≥2.
STARVE_MAX, 4, consecutive cycles a nonempty FIFO may lose to A before a_hold is raised; ≥1.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
a_we  in  1  W-stage write request
a_reg  in  5  W-stage destination register
a_data  in  32  W-stage write data
a_pc  in  32  W-stage instruction PC
b_valid  in  1  B request valid
b_ready  out  1  B request accepted at this posedge when b_valid is also high
b_reg  in  5  B destination register
b_data  in  32  B write data
b_pc  in  32  B instruction PC
rd_reg1  in  5  D-stage read register 1
rd_reg2  in  5  D-stage read register 2
pend_hit1  out  1  rd_reg1 matches a buffered B entry
pend_hit2  out  1  rd_reg2 matches a buffered B entry
RegWrite  out  1  register-file write enable
write_reg  out  5  register-file write address
wdata  out  32  register-file write data
PC  out  32  PC of the granted write
a_hold  out  1  registered; W stage must present no request next cycle
fifo_cnt  out  3  buffered B entries (0..DEPTH)
proto_err  out  1  sticky; A requested while a_hold was high

Behaviour:
Reset:
- FIFO empty, fifo_cnt=0, starvation counter=0, a_hold=0, proto_err=0.
- RegWrite is forced to 0 while reset is high.
- Reset mid-operation discards all buffered B entries.

Request qualification:
- A request = a_we && a_reg!=0.
- B handshake is accepted when b_valid && b_ready.
- An accepted B with b_reg==0 is consumed but not enqueued.

b_ready:
- b_ready = (fifo_cnt != DEPTH), derived only from registered state.
- When the FIFO is full, no enqueue occurs even if a dequeue happens that cycle.

Grant (combinational, same cycle), in priority order:
1. a_hold=1 and FIFO nonempty: grant B head. If an A request is present, it is dropped and proto_err is set.
2. A request present: grant A; outputs are a_reg/a_data/a_pc.
3. FIFO nonempty: grant B head; outputs are head reg/data/pc.
4. Otherwise: RegWrite=0; write_reg, wdata and PC are 0.

Latency and ordering:
- The A write reaches the register file at the same posedge it is presented.
- A B entry accepted at edge N is writable no earlier than edge N+1.
- The FIFO dequeues on a B grant. Enqueue and dequeue may occur in the same cycle (count unchanged), including when the FIFO is empty at accept (no bypass).
- B writes commit in acceptance order.
- A-vs-B ordering to the same register is the issuer's responsibility, enforced via pend_hit.

Starvation counter:
- Increments when an A grant occurs while the FIFO is nonempty.
- Resets to 0 on any B grant or when the FIFO is empty.
- When an increment takes it to STARVE_MAX, a_hold=1 for the next cycle only and the counter clears.
- a_hold is never asserted for two consecutive cycles.

Hazard outputs:
- pend_hit1 = rd_reg1!=0 and equal to the reg of any valid FIFO entry, including the entry being dequeued this cycle.
- pend_hit2 is the same for rd_reg2.
- Combinational from registered FIFO contents; not from b_* inputs.

Pointers and count:
- Read/write pointers wrap modulo DEPTH.
- fifo_cnt never exceeds DEPTH or goes negative.

Test Plan:
1. Reset, then a_we=1, a_reg=5, a_data=0x1234, a_pc=0x3000 -> same cycle RegWrite=1, write_reg=5, wdata=0x1234, PC=0x3000; a_reg=0 gives RegWrite=0.
2. With A idle, B pushes reg 8/0xAA then reg 9/0xBB on consecutive cycles -> writes to 8 then 9 on the cycles after each accept; fifo_cnt goes 1,1,0 (simultaneous enq/deq at the second accept).
3. A requests continuously while B pushes 3 entries with DEPTH=2 -> b_ready low after 2 accepts. After 4 A grants a_hold=1 for one cycle and B head is written. proto_err=1 if A was still requesting during hold; it stays 1 until reset.
4. FIFO holds reg 12; rd_reg1=12, rd_reg2=0 -> pend_hit1=1, pend_hit2=0. The flag clears the cycle after the reg-12 entry is written.
5. B accepts b_reg=0 -> fifo_cnt unchanged, no write. Then two entries are queued and reset is asserted for 1 cycle -> fifo_cnt=0, b_ready=1, no B write afterward.
6. Push/pop 10 entries with alternating A traffic -> pointers wrap; every B entry is written exactly once in order; each scoreboard check matches.
